eth_tx_arbiter: RTL and testbench

- Shares the single Ethernet transmit path (MAC tx framer and PHY byte stream) between the packet sources that reuse the IP/UDP header logic: ARP reply, ICMP reply, DHCP client and the UDP data streamer.
- Grants one requester at a time with round-robin fairness and issues a one-cycle start to the tx path.
- Holds the grant until the tx path reports the end of the frame, then enforces an inter-frame gap.
- A watchdog releases a grant whose frame never completes.

---
 rtl/eth_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_eth_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin arbiter sharing the Ethernet tx path, with inter-frame gap and watchdog
module eth_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       tx_done,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] sel,
    output logic                       tx_start,
    output logic                       busy,
    output logic                       timeout,
    output logic [7:0]                 timeout_count
);

    localparam int SEL_W   = $clog2(NUM_REQ);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_ptr_q, last_ptr_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tmo_count_q, tmo_count_d;

    logic [SEL_W-1:0]   pick;
    logic               pick_valid;

    // Scan from farthest to nearest after last_ptr so the nearest pending requester is the final assignment.
    always_comb begin
        int idx;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_ptr_q) + i) % NUM_REQ;
            if (req[idx]) begin
                pick       = SEL_W'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        last_ptr_d  = last_ptr_q;
        tx_start_d  = 1'b0;
        cnt_d       = cnt_q;
        tmo_count_d = tmo_count_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d    = NUM_REQ'(1) << pick;
                    sel_d      = pick;
                    last_ptr_d = pick;
                    tx_start_d = 1'b1;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d   = '0;
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (tx_done || cnt_q == TMO_LAST) begin
                    if (!tx_done && tmo_count_q != 8'hFF) begin
                        tmo_count_d = tmo_count_q + 8'd1;
                    end
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            last_ptr_q  <= SEL_W'(NUM_REQ - 1);
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            tmo_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            last_ptr_q  <= last_ptr_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            tmo_count_q <= tmo_count_d;
        end
    end

    assign grant         = grant_q;
    assign sel           = sel_q;
    assign tx_start      = tx_start_q;
    assign busy          = busy_q;
    assign timeout_count = tmo_count_q;
    // Decoded in the final watchdog cycle so a coincident tx_done can suppress it.
    assign timeout       = (state_q == S_ACTIVE) && (cnt_q == TMO_LAST) && !tx_done;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - scoreboard bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IFG     = 12;
    localparam int TMO     = 128;

    logic         clock;
    logic         reset_n;
    logic [3:0]   req;
    logic         tx_done;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         tx_start;
    logic         busy;
    logic         timeout;
    logic [7:0]   timeout_count;

    int           n_checks;
    int           n_fails;
    int           cyc;
    int           start_cyc;
    int           done_cyc;
    int           req_cyc;
    int           tmo_cyc;
    int           tmo_seen;
    int           tmo_before;
    int           exp_q[$];
    int           exp_idx;

    eth_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .tx_done       (tx_done),
        .grant         (grant),
        .sel           (sel),
        .tx_start      (tx_start),
        .busy          (busy),
        .timeout       (timeout),
        .timeout_count (timeout_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            check("grant_onehot0", 32'($onehot0(grant)), 1);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
                    exp_idx = exp_q.pop_front();
                    check("start_sel", 32'(sel), 32'(exp_idx));
                    check("start_grant", 32'(grant), 32'(1) << exp_idx);
                end
            end
            if (timeout) tmo_seen++;
        end
    end

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!tx_start && n < budget);
        check("start_seen", 32'(tx_start), 1);
        start_cyc = cyc;
    endtask

    task automatic wait_timeout(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!timeout && n < budget);
        check("timeout_seen", 32'(timeout), 1);
        tmo_cyc = cyc;
    endtask

    task automatic frame(input int len, input logic [3:0] drop);
        repeat (len) @(posedge clock);
        #1;
        tx_done  = 1'b1;
        req      = req & ~drop;
        done_cyc = cyc;
        @(posedge clock);
        #1;
        tx_done = 1'b0;
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        cyc      = 0;
        tmo_seen = 0;
        reset_n  = 1'b0;
        req      = '0;
        tx_done  = 1'b0;
        idle_wait(3);
        check("rst_grant", 32'(grant), 0);
        check("rst_sel", 32'(sel), 0);
        check("rst_start", 32'(tx_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_tcount", 32'(timeout_count), 0);
        reset_n = 1'b1;
        idle_wait(2);

        // single request
        req     = 4'b0100;
        req_cyc = cyc;
        exp_q.push_back(2);
        wait_start(4);
        check("req_to_grant", 32'(start_cyc - req_cyc), 1);
        @(negedge clock);
        check("start_width", 32'(tx_start), 0);
        check("active_busy", 32'(busy), 1);
        check("active_grant", 32'(grant), 32'h4);
        frame(99, 4'b0100);
        check("done_after_start", 32'(done_cyc - start_cyc), 100);
        @(negedge clock);
        check("grant_low_after_done", 32'(grant), 0);
        check("gap_busy", 32'(busy), 1);
        idle_wait(40);
        check("idle_busy", 32'(busy), 0);

        // round robin from reset
        reset_n = 1'b0;
        idle_wait(1);
        reset_n = 1'b1;
        req     = 4'b1111;
        for (int i = 0; i < 5; i++) exp_q.push_back(i % NUM_REQ);
        for (int i = 0; i < 5; i++) begin
            wait_start(40);
            if (i > 0) check("rr_spacing", 32'(start_cyc - done_cyc), IFG + 2);
            frame(50, (i == 4) ? 4'b1111 : 4'b0000);
        end
        idle_wait(20);

        // fairness: last winner 0, requester 3 holds req, 1 joins mid-frame
        req = 4'b1000;
        exp_q.push_back(3);
        wait_start(4);
        idle_wait(3);
        req[1] = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(3);
        frame(40, 4'b0000);
        wait_start(20);
        frame(20, 4'b0010);
        wait_start(20);
        frame(20, 4'b1000);
        idle_wait(20);

        // watchdog
        req = 4'b0001;
        exp_q.push_back(0);
        exp_q.push_back(2);
        wait_start(4);
        idle_wait(1);
        req[2] = 1'b1;
        wait_timeout(TMO + 10);
        check("timeout_latency", 32'(tmo_cyc - start_cyc), TMO);
        check("timeout_grant_held", 32'(grant), 32'h1);
        req[0] = 1'b0;
        @(negedge clock);
        check("timeout_width", 32'(timeout), 0);
        check("timeout_grant_low", 32'(grant), 0);
        check("timeout_count_1", 32'(timeout_count), 1);
        wait_start(20);
        check("timeout_to_start", 32'(start_cyc - tmo_cyc), IFG + 2);
        frame(20, 4'b0100);
        idle_wait(20);

        // tx_done pulses in IDLE and GAP are ignored
        tx_done = 1'b1;
        idle_wait(1);
        tx_done = 1'b0;
        idle_wait(3);
        check("idle_done_busy", 32'(busy), 0);
        check("idle_done_grant", 32'(grant), 0);
        req = 4'b0010;
        exp_q.push_back(1);
        exp_q.push_back(1);
        wait_start(4);
        frame(10, 4'b0000);
        idle_wait(3);
        tx_done = 1'b1;
        idle_wait(1);
        tx_done = 1'b0;
        wait_start(20);
        check("gap_done_spacing", 32'(start_cyc - done_cyc), IFG + 2);
        frame(10, 4'b0010);
        idle_wait(20);

        // tx_done on the watchdog's final cycle
        tmo_before = tmo_seen;
        req = 4'b0100;
        exp_q.push_back(2);
        wait_start(4);
        frame(TMO, 4'b0100);
        @(negedge clock);
        check("final_cycle_grant_low", 32'(grant), 0);
        check("final_cycle_no_timeout", 32'(tmo_seen - tmo_before), 0);
        check("final_cycle_tcount", 32'(timeout_count), 1);
        idle_wait(20);

        // saturation of the timeout counter
        req = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(0);
            wait_start(IFG + 4);
            if (i == 299) begin
                wait_timeout(TMO + 4);
                req = 4'b0000;
            end else begin
                wait_timeout(TMO + 4);
            end
        end
        idle_wait(20);
        check("tcount_saturated", 32'(timeout_count), 255);

        // asynchronous reset mid-frame
        req = 4'b0100;
        exp_q.push_back(2);
        wait_start(4);
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_tcount", 32'(timeout_count), 0);
        req = 4'b1001;
        idle_wait(2);
        reset_n = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(3);
        wait_start(4);
        frame(10, 4'b0001);
        wait_start(20);
        frame(10, 4'b1000);
        idle_wait(20);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
